stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000000: consecutive stable clk cycles needed to accept a button level (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter TICK_DIV, default 1000000: clk cycles per count_en pulse while counting.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_btn, input, 1 bit: raw asynchronous start/stop pushbutton, active-high.
REQ-006 The block SHALL have port lap_btn, input, 1 bit: raw asynchronous lap pushbutton, active-high.
REQ-007 The block SHALL have port clear_btn, input, 1 bit: raw asynchronous clear pushbutton, active-high.
REQ-008 The block SHALL have port count_en, output, 1 bit: one-cycle enable pulse that advances the BCD digit counter.
REQ-009 The block SHALL have port count_clr, output, 1 bit: one-cycle pulse that zeroes the digit counter.
REQ-010 The block SHALL have port freeze, output, 1 bit: high means the display path holds its last latched digits.
REQ-011 The block SHALL have port state, output, 2 bits: current FSM state code.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debounce counter; the debounced level SHALL change only after DB_CYCLES consecutive cycles of a differing synchronized level, with the counter restarting on any mismatch.
REQ-013 A press event SHALL be a one-cycle pulse on the 0->1 edge of the debounced level; worst-case latency from raw edge to event = 2 + DB_CYCLES + 1 cycles; release edges SHALL produce no event.
REQ-014 The FSM SHALL have states IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11, with state output equal to the registered state.
REQ-015 Transitions: IDLE-start->RUN; RUN-start->PAUSE; RUN-lap->LAP; LAP-lap->RUN; LAP-start->PAUSE; PAUSE-start->RUN; PAUSE-clear->IDLE; IDLE-clear->IDLE.
REQ-016 Clear events in RUN or LAP SHALL be ignored; lap events in IDLE or PAUSE SHALL be ignored.
REQ-017 When events coincide in one cycle, priority SHALL be clear > start > lap, and only the highest-priority applicable event SHALL act.
REQ-018 count_clr SHALL pulse for exactly one cycle, registered, in the cycle after an accepted clear event (IDLE or PAUSE).
REQ-019 freeze SHALL be 1 exactly while state==LAP, registered with the state.
REQ-020 A prescaler SHALL count 0..TICK_DIV-1 only in RUN or LAP, hold its value in PAUSE, and be 0 in IDLE.
REQ-021 count_en SHALL pulse for one cycle when the prescaler is TICK_DIV-1 in RUN or LAP; the prescaler SHALL wrap to 0 in that cycle.
REQ-022 A PAUSE->RUN transition SHALL resume from the held prescaler value, so no partial tick is lost or duplicated.
REQ-023 Prescaler and debounce counter widths SHALL be $clog2 of their parameters, with no overflow for parameter values >= 2.

Reset
REQ-024 While reset==0, state SHALL be IDLE and count_en, count_clr, freeze SHALL be 0; synchronizers, debounced levels, debounce counters and the prescaler SHALL be 0.
REQ-025 Reset asserted mid-operation (any state, any prescaler value) SHALL take effect asynchronously, and on release the block SHALL start in IDLE with no spurious event, even if a button is held.

Configuration
REQ-026 With macro STOPWATCH_LAP_EN defined, the lap button path and LAP state SHALL be implemented as specified.
REQ-027 Without STOPWATCH_LAP_EN, lap_btn SHALL be ignored, LAP SHALL be unreachable, freeze SHALL be constant 0, and no lap debounce logic SHALL be generated.

Verification (DB_CYCLES=4, TICK_DIV=5)
REQ-028 Reset release, start held 10 cycles -> state 00->01 at cycle 8 after the raw edge, count_en first pulse 5 cycles later, then every 5 cycles.
REQ-029 RUN, start pressed at prescaler=3, 20 cycles idle, start pressed again -> state 10 with no count_en while paused; after resume, count_en fires 2 cycles after re-entering RUN.
REQ-030 PAUSE, clear pressed -> count_clr is 1 for exactly one cycle, state 00, prescaler 0; clear pressed in RUN -> no count_clr, state stays 01.
REQ-031 RUN, start and lap debounced events in the same cycle -> state 10, freeze 0 (start wins).
REQ-032 RUN, lap press -> state 11, freeze 1, count_en continues every 5 cycles; second lap press -> state 01, freeze 0. With STOPWATCH_LAP_EN undefined -> state stays 01, freeze 0.
REQ-033 Start glitch 2 cycles wide (shorter than DB_CYCLES) -> no event; reset pulse in LAP -> freeze 0, state 00 immediately.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control block: per-button synchronizer + debounce + press-edge
// detection, a four-state run/pause/lap FSM, and a tick prescaler producing
// count_en / count_clr / freeze for a downstream BCD counter and display.
// Optional feature macro: STOPWATCH_LAP_EN (lap button path and LAP state).

module stopwatch_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchronize, accept a new level after DB_CYCLES stable cycles, pulse on rise.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; sync1 -> sync2 would collapse into one stage otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int TICK_DIV  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       lap_btn,
  input  logic       clear_btn,
  output logic       count_en,
  output logic       count_clr,
  output logic       freeze,
  output logic [1:0] state
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t        state_q;
  state_t        state_d;
  logic          clr_accept;
  logic          start_ev;
  logic          clear_ev;
  logic          lap_ev;
  logic [PW-1:0] presc;

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .btn(start_btn), .press(start_ev)
  );

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk(clk), .reset(reset), .btn(clear_btn), .press(clear_ev)
  );

`ifdef STOPWATCH_LAP_EN
  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk(clk), .reset(reset), .btn(lap_btn), .press(lap_ev)
  );
`else
  // Lap button has no load in this build; LAP is unreachable.
  logic unused_lap;
  assign unused_lap = lap_btn;
  assign lap_ev     = 1'b0;
`endif

  // Next state: clear beats start beats lap; only the first applicable event acts.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    clr_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_ev)      clr_accept = 1'b1;
        else if (start_ev) state_d    = RUN;
      end
      RUN: begin
        if (start_ev)    state_d = PAUSE;
        else if (lap_ev) state_d = LAP;
      end
      LAP: begin
        if (start_ev)    state_d = PAUSE;
        else if (lap_ev) state_d = RUN;
      end
      PAUSE: begin
        if (clear_ev) begin
          clr_accept = 1'b1;
          state_d    = IDLE;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, registered outputs and tick prescaler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      presc     <= '0;
`ifdef STOPWATCH_LAP_EN
      freeze    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_clr <= clr_accept;
`ifdef STOPWATCH_LAP_EN
      freeze    <= (state_d == LAP);
`endif
      count_en  <= 1'b0;
      if (clr_accept) begin
        presc <= '0;
      end else begin
        case (state_q)
          RUN, LAP: begin
            if (presc == PRESC_MAX) begin
              presc    <= '0;
              count_en <= 1'b1;
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE:   presc <= presc;
          default: presc <= '0;
        endcase
      end
    end
  end

`ifndef STOPWATCH_LAP_EN
  assign freeze = 1'b0;
`endif

  assign state = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DB_CYCLES=4, TICK_DIV=5.
// Stimulus pushes expected count_en cycles and expected state/freeze/count_clr
// events into queues; a negedge monitor pops and compares when the DUT shows them.
// A raw press sampled first at edge p+1 changes state at edge p+8.

module tb_stopwatch_ctrl;
  localparam int DB = 4;
  localparam int TD = 5;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0;
  logic       lap_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic       count_en;
  logic       count_clr;
  logic       freeze;
  logic [1:0] state;

  stopwatch_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk(clk),
    .reset(reset),
    .start_btn(start_btn),
    .lap_btn(lap_btn),
    .clear_btn(clear_btn),
    .count_en(count_en),
    .count_clr(count_clr),
    .freeze(freeze),
    .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] state;
    logic       freeze;
    logic       clr;
  } st_ev_t;

  st_ev_t st_q[$];
  int     ce_q[$];
  int     n_checks = 0;
  int     n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Expected-behaviour model state.
  logic [1:0] exp_state = 2'd0;
  int         seg_a = 0;   // cycle the current running segment started
  int         seg_h = 0;   // prescaler value at that cycle

  // Push expected count_en pulses in (lo, hi] for the current segment.
  task automatic push_ce(input int lo, input int hi);
    if (exp_state[0]) begin
      for (int n = seg_a + TD - seg_h; n <= hi; n += TD)
        if (n > lo) ce_q.push_back(n);
    end
  endtask

  // Apply button events taking effect at cycle a.
  task automatic apply(input int a, input logic s, input logic l, input logic c);
    logic [1:0] nx;
    logic       clr;
    logic       lap_ok;
    nx = exp_state;
    clr = 1'b0;
    lap_ok = LAP_EN & l;
    case (exp_state)
      2'd0: if (c) clr = 1'b1; else if (s) nx = 2'd1;
      2'd1: if (s) nx = 2'd2; else if (lap_ok) nx = 2'd3;
      2'd3: if (s) nx = 2'd2; else if (lap_ok) nx = 2'd1;
      default: if (c) begin clr = 1'b1; nx = 2'd0; end else if (s) nx = 2'd1;
    endcase
    if (exp_state[0] && !nx[0]) seg_h = (seg_h + a - seg_a) % TD;
    if (!exp_state[0] && nx[0]) seg_a = a;
    if (nx == 2'd0) seg_h = 0;
    if (nx != exp_state || clr)
      st_q.push_back('{cyc: a, state: nx, freeze: (nx == 2'd3), clr: clr});
    exp_state = nx;
  endtask

  // Press buttons for 10 cycles, release for 10; called at a negedge.
  task automatic press(input logic s, input logic l, input logic c);
    int p = cyc;
    int a = p + 8;
    push_ce(p, a);
    apply(a, s, l, c);
    push_ce(a, p + 20);
    start_btn = s;
    lap_btn   = l;
    clear_btn = c;
    repeat (10) @(negedge clk);
    start_btn = 1'b0;
    lap_btn   = 1'b0;
    clear_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic idle(input int n);
    push_ce(cyc, cyc + n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every count_en pulse and every state/freeze/clear event.
  logic [1:0] prev_state = 2'd0;
  logic       prev_freeze = 1'b0;
  st_ev_t     mon_st;
  int         mon_ce;
  always @(negedge clk) begin
    if (!reset) begin
      prev_state  = 2'd0;
      prev_freeze = 1'b0;
    end else begin
      if (count_en) begin
        if (ce_q.size() == 0) begin
          check("unexpected count_en", cyc, -1);
        end else begin
          mon_ce = ce_q.pop_front();
          check("count_en cycle", cyc, mon_ce);
        end
      end
      if (count_clr || state != prev_state || freeze != prev_freeze) begin
        if (st_q.size() == 0) begin
          check("unexpected state/freeze/clr event cycle", cyc, -1);
        end else begin
          mon_st = st_q.pop_front();
          check("event cycle", cyc, mon_st.cyc);
          check("state", int'(state), int'(mon_st.state));
          check("freeze", int'(freeze), int'(mon_st.freeze));
          check("count_clr", int'(count_clr), int'(mon_st.clr));
        end
      end
      prev_state  = state;
      prev_freeze = freeze;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    check("reset state", int'(state), 0);
    check("reset count_en", int'(count_en), 0);
    check("reset count_clr", int'(count_clr), 0);
    check("reset freeze", int'(freeze), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    press(1'b0, 1'b0, 1'b1);          // clear in IDLE: count_clr pulse, stays IDLE
    press(1'b1, 1'b0, 1'b0);          // start: IDLE -> RUN, first tick 5 cycles later
    idle(7);
    press(1'b0, 1'b0, 1'b1);          // clear in RUN: ignored, ticks continue
    while (((seg_h + cyc + 8 - seg_a) % TD) != 3) idle(1);
    press(1'b1, 1'b0, 1'b0);          // pause with prescaler held at 3
    idle(20);                          // no ticks while paused
    press(1'b1, 1'b0, 1'b0);          // resume: tick 2 cycles after RUN
    press(1'b0, 1'b1, 1'b0);          // lap: RUN -> LAP, freeze 1 (if enabled)
    idle(12);
    press(1'b0, 1'b1, 1'b0);          // lap again: LAP -> RUN
    press(1'b1, 1'b1, 1'b0);          // start + lap together: start wins -> PAUSE
    press(1'b0, 1'b0, 1'b1);          // clear in PAUSE: IDLE + count_clr

    push_ce(cyc, cyc + 2);            // 2-cycle glitch on start: no event
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    start_btn = 1'b0;
    idle(15);

    press(1'b1, 1'b0, 1'b0);          // start from cleared prescaler
    press(1'b0, 1'b1, 1'b0);          // into LAP (if enabled)

    check("ce queue drained before reset", ce_q.size(), 0);
    check("event queue drained before reset", st_q.size(), 0);
    #2 reset = 1'b0;                  // asynchronous reset mid-cycle
    #1;
    check("async reset state", int'(state), 0);
    check("async reset freeze", int'(freeze), 0);
    check("async reset count_en", int'(count_en), 0);
    exp_state = 2'd0;
    seg_h = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    idle(10);                         // nothing happens after release
    press(1'b1, 1'b0, 1'b0);          // fresh start after reset
    idle(12);

    check("ce queue drained at end", ce_q.size(), 0);
    check("event queue drained at end", st_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
